// File: rtl/sha256_arb_pkg.sv
// sha256_arb_pkg: shared state encoding and width helpers for the SHA-256 channel arbiter
package sha256_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sha256_tag_fifo.sv
// sha256_tag_fifo: in-order queue of channel tags for messages in flight in the hash core
// Ports: clk/sync_rst/en, push+din, pop+dout (head), full/empty flags.
// Push and pop in one cycle are both honoured; en low freezes the queue.
module sha256_tag_fifo
  import sha256_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         en,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = en & push & ~full;
  assign do_pop  = en & pop & ~empty;
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sha256_channel_arbiter.sv
// sha256_channel_arbiter: round-robin message arbiter in front of one SHA-256 core, routing digests back by tag
// Ports: ch_in_* per-channel 512-bit blocks in; core_in_* blocks to the core;
// core_out_* digests from the core; ch_out_* digest broadcast with one-hot valid;
// err_orphan sticky flag for a digest with no queued tag; ch_msg_count per-channel
// delivered-digest counters, built only when SHA256_ARB_STATS_EN is defined (else tied 0).
module sha256_channel_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 512,
  parameter int HASH_W    = 256,
  parameter int TAG_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   en,
  input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
  input  logic [NUM_CH-1:0]      ch_in_last,
  input  logic [NUM_CH-1:0]      ch_in_valid,
  output logic [NUM_CH-1:0]      ch_in_ready,
  output logic [DATA_W-1:0]      core_in_data,
  output logic                   core_in_last,
  output logic                   core_in_valid,
  input  logic                   core_in_ready,
  input  logic [HASH_W-1:0]      core_out_data,
  input  logic                   core_out_last,
  input  logic                   core_out_valid,
  output logic                   core_out_ready,
  output logic [HASH_W-1:0]      ch_out_data,
  output logic                   ch_out_last,
  output logic [NUM_CH-1:0]      ch_out_valid,
  input  logic [NUM_CH-1:0]      ch_out_ready,
  output logic                   err_orphan,
  output logic [NUM_CH*32-1:0]   ch_msg_count
);
  localparam int CW = ch_w(NUM_CH);
  arb_state_e    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d, rr_q, rr_d, pick, idx, head;
  logic          err_q, err_d;
  logic          locked, fwd_hs, ret_ok, push, pop, full, empty;
  assign locked = en & (state_q == LOCKED);
  assign fwd_hs = locked & ch_in_valid[grant_q] & core_in_ready;
  assign ret_ok = en & ~empty;
  // Descending scan so the lowest offset from rr_q wins.
  always_comb begin
    pick = rr_q;
    idx  = rr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_q) + k) % NUM_CH);
      if (ch_in_valid[idx]) pick = idx;
    end
  end
  // Grant cycle is a bubble: the tag is pushed, no block moves until LOCKED.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    push    = 1'b0;
    if (en && state_q == IDLE && |ch_in_valid && !full) begin
      state_d = LOCKED;
      grant_d = pick;
      push    = 1'b1;
    end
    if (fwd_hs && ch_in_last[grant_q]) begin
      state_d = IDLE;
      rr_d    = grant_q == CW'(NUM_CH - 1) ? '0 : grant_q + 1'b1;
    end
  end
  assign ch_in_ready    = (locked & core_in_ready) ? NUM_CH'(1) << grant_q : '0;
  assign core_in_valid  = locked & ch_in_valid[grant_q];
  assign core_in_last   = locked & ch_in_last[grant_q];
  assign core_in_data   = locked ? ch_in_data[grant_q*DATA_W +: DATA_W] : '0;
  assign ch_out_valid   = (ret_ok & core_out_valid) ? NUM_CH'(1) << head : '0;
  assign ch_out_data    = ret_ok ? core_out_data : '0;
  assign ch_out_last    = ret_ok & core_out_last;
  assign core_out_ready = ret_ok & ch_out_ready[head];
  assign pop            = core_out_valid & core_out_ready & core_out_last;
  assign err_d          = err_q | (en & core_out_valid & empty);
  assign err_orphan     = err_q;
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end
  sha256_tag_fifo #(.DEPTH(TAG_DEPTH), .W(CW)) u_tags (
    .clk      (clk),
    .sync_rst (sync_rst),
    .en       (en),
    .push     (push),
    .din      (grant_d),
    .pop      (pop),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );
`ifdef SHA256_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_CH];
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (pop) begin
      cnt_q[head] <= cnt_q[head] + 32'd1;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign ch_msg_count[g*32 +: 32] = cnt_q[g];
  end
`else
  assign ch_msg_count = '0;
`endif
endmodule

// File: tb/tb_sha256_channel_arbiter.sv
// tb_sha256_channel_arbiter: scoreboard bench for the SHA-256 channel arbiter
module tb_sha256_channel_arbiter;
  localparam int NUM_CH = 4, DATA_W = 512, HASH_W = 256, TAG_DEPTH = 8;
  typedef struct packed {
    logic [7:0]        ch;
    logic              last;
    logic [DATA_W-1:0] data;
  } blk_t;
  logic clk = 1'b0, sync_rst = 1'b1, en = 1'b1;
  logic [NUM_CH*DATA_W-1:0] ch_in_data;
  logic [NUM_CH-1:0] ch_in_last, ch_in_valid, ch_in_ready, ch_out_valid;
  logic [NUM_CH-1:0] ch_out_ready = '1;
  logic [DATA_W-1:0] core_in_data;
  logic core_in_last, core_in_valid, core_in_ready = 1'b1;
  logic [HASH_W-1:0] core_out_data, ch_out_data;
  logic core_out_last, core_out_valid, core_out_ready, ch_out_last, err_orphan;
  logic [NUM_CH*32-1:0] ch_msg_count;
  int n_vec = 0, n_err = 0;
  blk_t src_q [NUM_CH][$];
  blk_t fwd_q[$], dig_q[$], ret_q[$];
  logic [7:0] tag_exp[$];
  logic [31:0] cnt_exp [NUM_CH];
  logic [NUM_CH-1:0] hs;
  logic dhs;
  int n;

  sha256_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HASH_W(HASH_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .sync_rst(sync_rst), .en(en),
    .ch_in_data(ch_in_data), .ch_in_last(ch_in_last), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
    .core_in_data(core_in_data), .core_in_last(core_in_last), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_last(core_out_last), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .ch_out_data(ch_out_data), .ch_out_last(ch_out_last), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
    .err_orphan(err_orphan), .ch_msg_count(ch_msg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] r;
    for (int w = 0; w < DATA_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_in_valid[i] = src_q[i].size() > 0;
      ch_in_data[i*DATA_W +: DATA_W] = '0;
      ch_in_last[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        ch_in_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
        ch_in_last[i] = src_q[i][0].last;
      end
    end
    core_out_valid = dig_q.size() > 0;
    core_out_data  = '0;
    core_out_last  = 1'b0;
    if (dig_q.size() > 0) begin
      core_out_data = dig_q[0].data[HASH_W-1:0];
      core_out_last = dig_q[0].last;
    end
  endtask

  task automatic send(input int ch, input int nb);
    blk_t b;
    for (int k = 0; k < nb; k++) begin
      b.ch = 8'(ch);
      b.last = (k == nb - 1);
      b.data = rnd();
      src_q[ch].push_back(b);
      fwd_q.push_back(b);
    end
    tag_exp.push_back(8'(ch));
    drive();
  endtask

  task automatic digest(input logic [HASH_W-1:0] d);
    blk_t b;
    if (tag_exp.size() == 0) chk("digest_no_tag", 1, 0);
    else begin
      b.ch = tag_exp.pop_front();
      b.last = 1'b1;
      b.data = DATA_W'(d);
      dig_q.push_back(b);
      ret_q.push_back(b);
    end
    drive();
  endtask

  task automatic tick();
    blk_t e;
    @(negedge clk);
    if (core_in_valid && core_in_ready) begin
      if (fwd_q.size() == 0) chk("fwd_extra", 1, 0);
      else begin
        e = fwd_q.pop_front();
        chk("fwd_grant", DATA_W'(ch_in_valid & ch_in_ready), DATA_W'(1) << e.ch);
        chk("fwd_data", core_in_data, e.data);
        chk("fwd_last", DATA_W'(core_in_last), DATA_W'(e.last));
      end
    end
    hs  = ch_in_valid & ch_in_ready;
    dhs = core_out_valid & core_out_ready;
    if (dhs) begin
      if (ret_q.size() == 0) chk("ret_extra", 1, 0);
      else begin
        e = ret_q.pop_front();
        chk("ret_valid", DATA_W'(ch_out_valid), DATA_W'(1) << e.ch);
        chk("ret_data", DATA_W'(ch_out_data), e.data);
        if (core_out_last) cnt_exp[e.ch[1:0]]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) if (hs[i]) void'(src_q[i].pop_front());
    if (dhs) void'(dig_q.pop_front());
    drive();
  endtask

  task automatic run_fwd(input string tag, input int max, output int cnt);
    cnt = 0;
    while (fwd_q.size() > 0 && cnt < max) begin
      tick();
      cnt++;
    end
    if (fwd_q.size() > 0) chk({tag, "_fwd_timeout"}, DATA_W'(fwd_q.size()), '0);
  endtask

  task automatic run_ret(input string tag, input int max);
    int c = 0;
    while (ret_q.size() > 0 && c < max) begin
      tick();
      c++;
    end
    if (ret_q.size() > 0) chk({tag, "_ret_timeout"}, DATA_W'(ret_q.size()), '0);
  endtask

  task automatic reset();
    sync_rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      src_q[i].delete();
      cnt_exp[i] = '0;
    end
    fwd_q.delete(); dig_q.delete(); ret_q.delete(); tag_exp.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    logic [NUM_CH*32-1:0] c = '0;
`ifdef SHA256_ARB_STATS_EN
    for (int i = 0; i < NUM_CH; i++) c[i*32 +: 32] = cnt_exp[i];
`endif
    chk(tag, DATA_W'(ch_msg_count), DATA_W'(c));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    drive();
    reset();
    chk("rst_ch_in_ready", DATA_W'(ch_in_ready), '0);
    chk("rst_core_in_valid", DATA_W'(core_in_valid), '0);
    chk("rst_core_in_data", core_in_data, '0);
    chk("rst_core_out_ready", DATA_W'(core_out_ready), '0);
    chk("rst_ch_out_valid", DATA_W'(ch_out_valid), '0);
    chk("rst_ch_out_data", DATA_W'(ch_out_data), '0);
    chk("rst_err", DATA_W'(err_orphan), '0);
    chk("rst_counts", DATA_W'(ch_msg_count), '0);
    // single channel, 3 blocks: one bubble then 3 back-to-back transfers
    send(2, 3);
    run_fwd("single", 10, n);
    chk("single_cycles", DATA_W'(n), DATA_W'(4));
    digest({64'hABCD_0123_4567_89AB, 192'h0});
    run_ret("single", 5);
    // fairness from reset: strict 0,1,2,3,0,1,2,3 with all channels held valid
    reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < NUM_CH; c++) send(c, 1);
    run_fwd("fair", 40, n);
    chk("fair_cycles", DATA_W'(n), DATA_W'(16));
    for (int k = 0; k < 8; k++) digest(rnd());
    run_ret("fair", 20);
    // lock: ch 1 owns the core until its last beat, ch 0 waits
    send(1, 3);
    tick();
    tick();
    send(0, 1);
    n = 0;
    while (fwd_q.size() > 0 && n < 40) begin
      core_in_ready = ~core_in_ready;
      tick();
      if (fwd_q.size() > 1) chk("lock_ch0_ready", DATA_W'(ch_in_ready[0]), '0);
      n++;
    end
    if (fwd_q.size() > 0) chk("lock_fwd_timeout", DATA_W'(fwd_q.size()), '0);
    core_in_ready = 1'b1;
    digest(rnd());
    digest(rnd());
    run_ret("lock", 10);
    // en low mid-message freezes, resumes without a new bubble
    send(2, 2);
    tick();
    tick();
    en = 1'b0;
    repeat (3) begin
      tick();
      chk("en_core_in_valid", DATA_W'(core_in_valid), '0);
      chk("en_ch_in_ready", DATA_W'(ch_in_ready), '0);
    end
    chk("en_pending", DATA_W'(fwd_q.size()), DATA_W'(1));
    en = 1'b1;
    run_fwd("en", 10, n);
    chk("en_resume", DATA_W'(n), DATA_W'(1));
    digest(rnd());
    run_ret("en", 5);
    // full tag queue: 9 offered, 8 accepted until a digest frees a slot
    reset();
    for (int k = 0; k < 9; k++) send(k % NUM_CH, 1);
    repeat (26) tick();
    chk("full_pending", DATA_W'(fwd_q.size()), DATA_W'(1));
    chk("full_core_in_valid", DATA_W'(core_in_valid), '0);
    digest(rnd());
    run_ret("full", 5);
    run_fwd("full9", 10, n);
    for (int k = 0; k < 8; k++) digest(rnd());
    run_ret("full", 20);
    // backpressure on ch 3 stalls the ch 0 digest behind it
    send(3, 1);
    send(0, 1);
    run_fwd("ooo", 10, n);
    ch_out_ready = 4'b0111;
    digest(rnd());
    digest(rnd());
    repeat (5) begin
      tick();
      chk("ooo_core_out_ready", DATA_W'(core_out_ready), '0);
      chk("ooo_ch_out_valid", DATA_W'(ch_out_valid), DATA_W'(4'b1000));
    end
    chk("ooo_held", DATA_W'(ret_q.size()), DATA_W'(2));
    ch_out_ready = '1;
    run_ret("ooo", 10);
    chk_counts("stats_counts");
    // orphan digest with empty tag queue
    chk("orph_pre", DATA_W'(err_orphan), '0);
    dig_q.push_back(blk_t'{ch: 8'd0, last: 1'b1, data: rnd()});
    drive();
    tick();
    chk("orph_ready", DATA_W'(core_out_ready), '0);
    chk("orph_err", DATA_W'(err_orphan), DATA_W'(1));
    dig_q.delete();
    drive();
    repeat (3) tick();
    chk("orph_sticky", DATA_W'(err_orphan), DATA_W'(1));
    chk_counts("orph_counts");
    reset();
    chk("orph_cleared", DATA_W'(err_orphan), '0);
    chk("post_rst_counts", DATA_W'(ch_msg_count), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sha256_channel_arbiter.md
# sha256_channel_arbiter

Multi-channel front end for a single SHA-256 hash compression core. It accepts padded 512-bit message blocks from NUM_CH independent requesters and arbitrates round-robin at message granularity. Each message's channel index is recorded in an in-order tag queue, and every 256-bit digest returned by the core is routed back to the channel that issued the message. It sits between per-channel message builders and the shared compression core, generalising the single-stream engine to N streams.

## Interface
- NUM_CH, 4, number of requester channels (≥2)
- DATA_W, 512, message block width
- HASH_W, 256, digest width
- TAG_DEPTH, 8, max messages in flight in the core (power of 2, ≥2)
- clk  in  1  clock; all logic rising-edge
- sync_rst  in  1  reset; synchronous, active-high
- en  in  1  global enable; low freezes all state and forces all ready/valid outputs low
- ch_in_data  in  NUM_CH*DATA_W  per-channel block; channel i at [i*DATA_W +: DATA_W]
- ch_in_last  in  NUM_CH  final block of a message
- ch_in_valid  in  NUM_CH  per-channel valid
- ch_in_ready  out  NUM_CH  per-channel ready
- core_in_data  out  DATA_W  block to core
- core_in_last / core_in_valid  out  1  to core
- core_in_ready  in  1  from core
- core_out_data  in  HASH_W  digest from core
- core_out_last / core_out_valid  in  1  from core
- core_out_ready  out  1  to core
- ch_out_data  out  HASH_W  digest, broadcast to all channels
- ch_out_last  out  1  copy of core_out_last
- ch_out_valid  out  NUM_CH  one-hot valid to owning channel
- ch_out_ready  in  NUM_CH  per-channel ready
- err_orphan  out  1  sticky; digest arrived with tag queue empty
- ch_msg_count  out  NUM_CH*32  per-channel delivered-digest count (see Configuration)

## Operation
- States: IDLE, LOCKED. Registers: grant (CH_W), rr_ptr (CH_W), tag queue, err_orphan.
- IDLE: if en, any ch_in_valid set and tag queue not full, grant = first valid channel at or after rr_ptr (wrapping modulo NUM_CH). Push grant into tag queue and move to LOCKED. No block is transferred in this cycle.
- LOCKED: core_in_* mux from channel grant. On core handshake with core_in_last=1: rr_ptr <= (grant+1) mod NUM_CH, go IDLE.
- The grant is never broken mid-message. Other channels hold off regardless of their valid.
- Return path: head = tag queue head. ch_out_valid[head] = core_out_valid & en & !empty. core_out_ready = en & !empty & ch_out_ready[head]. Pop on handshake with core_out_last=1.
- core_out_valid while queue empty: hold core_out_ready low and set err_orphan, which stays set until sync_rst.
- Push and pop in the same cycle are both honoured; the count is unchanged.
- Full queue: IDLE does not grant. A message in progress always completes.

## Timing
- Reset values: state IDLE, grant 0, rr_ptr 0, queue empty, all ready/valid outputs 0, err_orphan 0, counters 0, data outputs 0.
- ch_in_ready[i] = en & LOCKED & grant==i & core_in_ready (combinational). core_in_valid = en & LOCKED & ch_in_valid[grant].
- Forward path has zero-cycle latency. Arbitration costs one bubble cycle per message.
- Return path is combinational; no added latency.
- sync_rst mid-message drops the grant and flushes the queue. The core must be reset by the same sync_rst.
- en low: no state change, no handshakes. Operation resumes exactly where it left off.

## Configuration
- SHA256_ARB_STATS_EN defined: ch_msg_count[i] increments on each delivered digest (handshake with last) for channel i. It wraps at 2^32 and resets to 0.
- Undefined: counters are not built and ch_msg_count is tied to 0. The port remains present, so the interface does not change.

## Structure
- Package sha256_arb_pkg holds the state enum {IDLE, LOCKED}, the CH_W = (NUM_CH>1 ? $clog2(NUM_CH) : 1) helper and the tag-queue count width helper.
- Sub-module sha256_tag_fifo: TAG_DEPTH×CH_W synchronous FIFO with full/empty flags, simultaneous push/pop and the same clk/sync_rst/en.
- The round-robin pick is combinational logic inside this block.

## Test plan
- Single channel: ch 2 sends a 3-block message while core_in_ready=1. Response: grant bubble, then 3 consecutive transfers, tag 2 queued. Digest 0xABCD… appears only on ch_out_valid[2].
- Fairness: all 4 channels continuously valid with 1-block messages. Grant order is 0,1,2,3,0,… and no channel is granted twice before the others.
- Lock: ch 1 mid-message with core_in_ready toggling and ch 0 asserting valid. Ch 0 gets no ready until ch 1's last beat is accepted.
- Full queue: TAG_DEPTH=8, core_out_valid held low, 9 one-block messages offered. Exactly 8 are accepted. After one digest is popped, the 9th is granted.
- Out-of-order backpressure: digests for ch 3 then ch 0, with ch_out_ready[3]=0 for 5 cycles. core_out_ready stays 0 and the ch 0 digest waits. Order is preserved.
- Orphan: core_out_valid=1 with the queue empty. Response: err_orphan=1 next cycle, core_out_ready=0, cleared only by sync_rst. With SHA256_ARB_STATS_EN, counts match delivered digests.
